// File: rtl/dmem_responder.sv
// Data-memory target for the load/store port. It accepts one request at a time,
// waits a fixed number of cycles, then answers on a separate response channel.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_0,
  input  logic        reset_0,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // state | meaning
  // IDLE  | ready for a request, req_ready high
  // WAIT  | request captured, counting down the wait states
  // RESP  | response presented until rsp_ready
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam int         DEPTH     = 2 ** ADDR_WIDTH;

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  ready_q;
  logic                  valid_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic                  cap_we;
  logic [31:0]           cap_addr;
  logic [31:0]           cap_wdata;
  logic [1:0]            cap_size;
  logic                  cap_uns;

  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  exec_en;
  logic                  acc_err;
  logic                  misaligned;
  logic                  out_of_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            wr_be;
  logic [31:0]           wr_word;
  logic [31:0]           rd_word;
  logic [31:0]           byte_sh;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_data;

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // ready_q is only ever high in IDLE, so it doubles as the state qualifier
  assign accept  = req_valid & ready_q;
  assign exec_en = (state == ST_WAIT) && (wait_cnt == 4'd0);

  assign word_idx     = cap_addr[ADDR_WIDTH+1:2];
  assign out_of_range = (cap_addr >> (ADDR_WIDTH + 2)) != 32'd0;

  always_comb begin
    misaligned = 1'b0;
    case (cap_size)
      2'b01:   misaligned = cap_addr[0];
      2'b10:   misaligned = cap_addr[1:0] != 2'b00;
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  assign acc_err = misaligned | out_of_range;

  always_comb begin
    wr_be   = 4'b0000;
    wr_word = cap_wdata;
    case (cap_size)
      2'b00: begin
        wr_be   = 4'b0001 << cap_addr[1:0];
        wr_word = {4{cap_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = cap_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{cap_wdata[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  assign rd_word = mem[word_idx];
  assign byte_sh = rd_word >> {cap_addr[1:0], 3'b000};
  assign ld_byte = byte_sh[7:0];
  assign ld_half = cap_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    case (cap_size)
      2'b00:   ld_data = cap_uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = cap_uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  // Write gated by reset so a store caught by reset never lands
  always_ff @(posedge clk_0) begin
    if (reset_0 && exec_en && cap_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_0) begin
    if (!reset_0) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_size  <= 2'b00;
      cap_uns   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_size  <= req_size;
            cap_uns   <= req_unsigned;
            wait_cnt  <= WAIT_INIT;
            ready_q   <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            valid_q <= 1'b1;
            err_q   <= acc_err;
            rdata_q <= (acc_err || cap_we) ? 32'd0 : ld_data;
            state   <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          ready_q <= 1'b0;
          valid_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (wait states 1, 3, 0) sharing the
// request bus, each selected in turn; expectations are queued at accept time.
module tb_dmem_responder;

  typedef struct {
    logic [1:0]  sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_0 = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        req_we = 1'b0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'b00;
  logic [1:0]  sel = 2'd0;

  logic [2:0]  vld_w, rrdy_w, rdy_w, rvld_w, rerr_w;
  logic [31:0] rdata_w [3];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t tbl[20];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      vld_w[i]  = req_valid && (sel == 2'(i));
      rrdy_w[i] = rsp_ready && (sel == 2'(i));
    end
  end

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
    .clk_0(clk), .reset_0(reset_0), .req_valid(vld_w[0]), .req_ready(rdy_w[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(rvld_w[0]), .rsp_ready(rrdy_w[0]),
    .rsp_rdata(rdata_w[0]), .rsp_err(rerr_w[0]));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
    .clk_0(clk), .reset_0(reset_0), .req_valid(vld_w[1]), .req_ready(rdy_w[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(rvld_w[1]), .rsp_ready(rrdy_w[1]),
    .rsp_rdata(rdata_w[1]), .rsp_err(rerr_w[1]));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .clk_0(clk), .reset_0(reset_0), .req_valid(vld_w[2]), .req_ready(rdy_w[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(rvld_w[2]), .rsp_ready(rrdy_w[2]),
    .rsp_rdata(rdata_w[2]), .rsp_err(rerr_w[2]));

  function automatic int ws_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 3 : 0;
  endfunction

  function automatic vec_t mk(input logic [1:0] s, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [1:0] sz, input logic u,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.sel = s; v.we = we; v.addr = a; v.wdata = wd; v.size = sz; v.uns = u;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Present a request and return the cycle number of the accepting edge
  task automatic drive_accept(input vec_t v, output int acc);
    int n = 0;
    sel = v.sel; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns; req_valid = 1'b1;
    while (!rdy_w[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_w[sel]) begin
      timeout("req_ready");
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
  endtask

  task automatic collect(input int acc, input int hold);
    exp_t e;
    int   n = 0;
    while (!rvld_w[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rvld_w[sel]) begin
      timeout("rsp_valid");
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    chk("latency", 32'(cyc - acc), 32'(1 + ws_of(sel)));
    e = sb.pop_front();
    chk("rdata", rdata_w[sel], e.rdata);
    chk("err", {31'd0, rerr_w[sel]}, {31'd0, e.err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rvld_w[sel]}, 32'd1);
      chk("hold_rdata", rdata_w[sel], e.rdata);
      chk("hold_req_ready", {31'd0, rdy_w[sel]}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (hold > 0) begin
      chk("post_valid", {31'd0, rvld_w[sel]}, 32'd0);
      chk("post_req_ready", {31'd0, rdy_w[sel]}, 32'd1);
    end
  endtask

  task automatic do_op(input vec_t v, input int hold);
    exp_t e;
    int   acc;
    drive_accept(v, acc);
    if (acc < 0) return;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    collect(acc, hold);
  endtask

  initial begin
    vec_t v;
    int   acc;
    // sel, we, addr, wdata, size, uns, expected rdata, expected err
    tbl[0]  = mk(0, 1, 32'h10,   32'hDEADBEEF, 2'b10, 0, 32'h0,        0);
    tbl[1]  = mk(0, 0, 32'h10,   32'h0,        2'b10, 0, 32'hDEADBEEF, 0);
    tbl[2]  = mk(0, 1, 32'h13,   32'h80,       2'b00, 0, 32'h0,        0);
    tbl[3]  = mk(0, 0, 32'h13,   32'h0,        2'b00, 0, 32'hFFFFFF80, 0);
    tbl[4]  = mk(0, 0, 32'h13,   32'h0,        2'b00, 1, 32'h00000080, 0);
    tbl[5]  = mk(0, 0, 32'h10,   32'h0,        2'b10, 0, 32'h80ADBEEF, 0);
    tbl[6]  = mk(0, 0, 32'h12,   32'h0,        2'b01, 0, 32'hFFFF80AD, 0);
    tbl[7]  = mk(0, 1, 32'h11,   32'h1234,     2'b01, 0, 32'h0,        1);
    tbl[8]  = mk(0, 0, 32'h10,   32'h0,        2'b10, 0, 32'h80ADBEEF, 0);
    tbl[9]  = mk(0, 0, 32'h1000, 32'h0,        2'b10, 0, 32'h0,        1);
    tbl[10] = mk(0, 0, 32'h10,   32'h0,        2'b11, 0, 32'h0,        1);
    tbl[11] = mk(0, 0, 32'h12,   32'h0,        2'b01, 1, 32'h000080AD, 0);
    tbl[12] = mk(0, 0, 32'h10,   32'h0,        2'b01, 0, 32'hFFFFBEEF, 0);
    tbl[13] = mk(0, 0, 32'h10,   32'h0,        2'b10, 1, 32'h80ADBEEF, 0);
    tbl[14] = mk(0, 0, 32'h12,   32'h0,        2'b10, 0, 32'h0,        1);
    tbl[15] = mk(0, 1, 32'hFFC,  32'h01020304, 2'b10, 0, 32'h0,        0);
    tbl[16] = mk(0, 0, 32'hFFD,  32'h0,        2'b00, 1, 32'h00000003, 0);
    tbl[17] = mk(1, 1, 32'h20,   32'hA5A5A5A5, 2'b10, 0, 32'h0,        0);
    tbl[18] = mk(2, 1, 32'h10,   32'hDEADBEEF, 2'b10, 0, 32'h0,        0);
    tbl[19] = mk(2, 0, 32'h10,   32'h0,        2'b10, 0, 32'hDEADBEEF, 0);

    reset_0 = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_req_ready", {31'd0, rdy_w[i]}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rvld_w[i]}, 32'd0);
      chk("rst_rsp_rdata", rdata_w[i], 32'd0);
      chk("rst_rsp_err", {31'd0, rerr_w[i]}, 32'd0);
    end
    reset_0 = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) do_op(tbl[i], 0);

    // Response back-pressure: held three cycles, then released
    do_op(mk(0, 0, 32'h10, 32'h0, 2'b10, 0, 32'h80ADBEEF, 0), 3);

    // Reset while a store sits in WAIT: the store must be dropped
    drive_accept(mk(1, 1, 32'h20, 32'h55, 2'b00, 0, 32'h0, 0), acc);
    reset_0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_rsp_valid", {31'd0, rvld_w[1]}, 32'd0);
    chk("midrst_req_ready", {31'd0, rdy_w[1]}, 32'd0);
    reset_0 = 1'b1;
    repeat (2) @(negedge clk);
    do_op(mk(1, 0, 32'h20, 32'h0, 2'b10, 0, 32'hA5A5A5A5, 0), 0);
    do_op(mk(1, 0, 32'h20, 32'h0, 2'b00, 1, 32'h000000A5, 0), 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
